// File: rtl/vga_if.sv
// vga_if: VGA timing stream bundle (counters, syncs, blanks, colour).
// master drives the stream, slave consumes it.
interface vga_if;
  logic [10:0] vcount;
  logic [10:0] hcount;
  logic        vsync;
  logic        hsync;
  logic        vblnk;
  logic        hblnk;
  logic [11:0] rgb;

  modport master (
    output vcount, hcount, vsync, hsync,
    output vblnk, hblnk, rgb
  );

  modport slave (
    input vcount, hcount, vsync, hsync,
    input vblnk, hblnk, rgb
  );
endinterface

// File: rtl/draw_sprite_layers.sv
// draw_sprite_layers: N-layer colour-keyed sprite overlay, 2 clk latency.
// Build option SPRITE_COLLISION_EN adds a per-frame overlap flag.
module draw_sprite_layers #(
  parameter int          N_LAYERS = 4,
  parameter int          SPR_W    = 64,
  parameter int          SPR_H    = 64,
  parameter logic [11:0] KEY_RGB  = 12'h0F0,
  localparam int         AW = $clog2(SPR_W*SPR_H)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  vga_if.slave                         vga_in,
  vga_if.master                        vga_out,
  input  logic [N_LAYERS-1:0]          layer_en,
  input  logic [N_LAYERS-1:0][11:0]    xpos,
  input  logic [N_LAYERS-1:0][11:0]    ypos,
  output logic [N_LAYERS-1:0][AW-1:0]  rom_addr,
  input  logic [N_LAYERS-1:0][11:0]    rom_pixel,
  output logic                         collision
);

  localparam int WB = $clog2(SPR_W);
  localparam int HB = $clog2(SPR_H);
  localparam logic [12:0] XSPAN = 13'(SPR_W - 1);
  localparam logic [12:0] YSPAN = 13'(SPR_H - 1);

  typedef struct packed {
    logic [10:0] vc;
    logic [10:0] hc;
    logic        vs;
    logic        hs;
    logic        vb;
    logic        hb;
    logic [11:0] rgb;
  } tim_t;

  logic                        vb_q;
  logic                        cap;
  logic [N_LAYERS-1:0]         en_q;
  logic [N_LAYERS-1:0][11:0]   x_q;
  logic [N_LAYERS-1:0][11:0]   y_q;

  logic [12:0]                 hc13;
  logic [12:0]                 vc13;
  logic                        act;
  logic [N_LAYERS-1:0]         hit_d;
  logic [N_LAYERS-1:0][AW-1:0] addr_d;
  tim_t                        tin;

  logic [N_LAYERS-1:0][AW-1:0] addr_q;
  logic [N_LAYERS-1:0]         hit1_q;
  logic [N_LAYERS-1:0]         hit2_q;
  tim_t                        t1_q;
  tim_t                        t2_q;

  logic [N_LAYERS-1:0]         opq;
  logic [11:0]                 rgb_mix;

  // First vblank cycle of a frame is the only point new positions land.
  assign cap = vga_in.vblnk & ~vb_q;

  // Shadow copies of the layer controls, frozen for a whole frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vb_q <= 1'b0;
      en_q <= '0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      vb_q <= vga_in.vblnk;
      if (cap) begin
        en_q <= layer_en;
        x_q  <= xpos;
        y_q  <= ypos;
      end
    end
  end

  assign hc13 = {2'b00, vga_in.hcount};
  assign vc13 = {2'b00, vga_in.vcount};
  assign act  = ~vga_in.hblnk & ~vga_in.vblnk;

  assign tin = '{
    vc:  vga_in.vcount,
    hc:  vga_in.hcount,
    vs:  vga_in.vsync,
    hs:  vga_in.hsync,
    vb:  vga_in.vblnk,
    hb:  vga_in.hblnk,
    rgb: vga_in.rgb
  };

  // Stage 0: 13-bit window test so x+SPR_W cannot wrap; local address.
  always_comb begin
    hit_d  = '0;
    addr_d = '0;
    for (int l = 0; l < N_LAYERS; l++) begin
      if (en_q[l] && act &&
          hc13 >= {1'b0, x_q[l]} &&
          hc13 <= {1'b0, x_q[l]} + XSPAN &&
          vc13 >= {1'b0, y_q[l]} &&
          vc13 <= {1'b0, y_q[l]} + YSPAN) begin
        hit_d[l]  = 1'b1;
        addr_d[l] = {
          vga_in.vcount[HB-1:0] - y_q[l][HB-1:0],
          vga_in.hcount[WB-1:0] - x_q[l][WB-1:0]
        };
      end
    end
  end

  // Stages 0/1: register address, then line hits/timing up with ROM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      hit1_q <= '0;
      hit2_q <= '0;
      t1_q   <= '0;
      t2_q   <= '0;
    end else begin
      addr_q <= addr_d;
      hit1_q <= hit_d;
      hit2_q <= hit1_q;
      t1_q   <= tin;
      t2_q   <= t1_q;
    end
  end

  assign rom_addr = addr_q;

  // Stage 2: a layer is opaque when hit and not the colour key.
  always_comb begin
    opq = '0;
    for (int l = 0; l < N_LAYERS; l++) begin
      opq[l] = hit2_q[l] && (rom_pixel[l] != KEY_RGB);
    end
  end

  // Stage 2: lowest-index opaque layer wins, else background.
  always_comb begin
    rgb_mix = t2_q.rgb;
    for (int l = N_LAYERS - 1; l >= 0; l--) begin
      if (opq[l]) rgb_mix = rom_pixel[l];
    end
  end

  assign vga_out.vcount = t2_q.vc;
  assign vga_out.hcount = t2_q.hc;
  assign vga_out.vsync  = t2_q.vs;
  assign vga_out.hsync  = t2_q.hs;
  assign vga_out.vblnk  = t2_q.vb;
  assign vga_out.hblnk  = t2_q.hb;
  assign vga_out.rgb    = rgb_mix;

`ifdef SPRITE_COLLISION_EN
  logic multi;
  logic seen;
  logic flag_q;
  logic col_q;

  // Two or more opaque layers on the same output pixel.
  always_comb begin
    multi = 1'b0;
    seen  = 1'b0;
    for (int l = 0; l < N_LAYERS; l++) begin
      if (opq[l]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
      end
    end
  end

  // Sticky flag per frame; published and restarted at each capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      col_q  <= 1'b0;
    end else if (cap) begin
      col_q  <= flag_q;
      flag_q <= multi;
    end else if (multi) begin
      flag_q <= 1'b1;
    end
  end

  assign collision = col_q;
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_draw_sprite_layers.sv
// tb_draw_sprite_layers: frame-level model of the compositor vs the DUT.
// Directed scans over small screen windows with literal spot values.
module tb_draw_sprite_layers;

  localparam int          N   = 4;
  localparam int          SW  = 64;
  localparam int          SH  = 64;
  localparam int          AW  = 12;
  localparam logic [11:0] KEY = 12'h0F0;
`ifdef SPRITE_COLLISION_EN
  localparam logic COLX = 1'b1;
`else
  localparam logic COLX = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]      ph;
    logic [3:0]      nopq;
    logic [N*AW-1:0] addr;
    logic [10:0]     hc;
    logic [10:0]     vc;
    logic            hs;
    logic            vs;
    logic            hb;
    logic            vb;
    logic [11:0]     rgb;
  } exp_t;

  logic clk;
  logic rst_n;
  vga_if vin();
  vga_if vout();
  logic [N-1:0]         layer_en;
  logic [N-1:0][11:0]   xpos;
  logic [N-1:0][11:0]   ypos;
  logic [N-1:0][AW-1:0] rom_addr;
  logic [N-1:0][11:0]   rom_pixel;
  logic                 collision;

  logic [N-1:0]       rom_pat;
  logic [N-1:0][11:0] rom_col;
  logic [3:0]         ph;

  int total = 0;
  int bad   = 0;

  draw_sprite_layers #(
    .N_LAYERS(N), .SPR_W(SW), .SPR_H(SH), .KEY_RGB(KEY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_in(vin), .vga_out(vout),
    .layer_en(layer_en), .xpos(xpos), .ypos(ypos),
    .rom_addr(rom_addr), .rom_pixel(rom_pixel),
    .collision(collision)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sprite image: either a flat colour or an address-derived pattern.
  function automatic logic [11:0] rom_fn(input int l, input int a);
    logic [11:0] v;
    if (rom_pat[l]) begin
      v = 12'(a ^ (l << 9));
      v = v | 12'h800;
    end else begin
      v = rom_col[l];
    end
    return v;
  endfunction

  always @(posedge clk) begin
    for (int l = 0; l < N; l++) rom_pixel[l] <= rom_fn(l, int'(rom_addr[l]));
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  exp_t e1, e2, cur;
  logic [N-1:0]     s_en;
  int               s_x [N];
  int               s_y [N];
  logic             pvb;
  logic             mflag;
  logic             mcol;
  int               mh, mv, ma;
  logic [11:0]      mp;

  // Reference: paint each pixel from the frame's latched layer list.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1 = '0; e2 = '0; s_en = '0; pvb = 1'b0;
      mflag = 1'b0; mcol = 1'b0;
      for (int l = 0; l < N; l++) begin s_x[l] = 0; s_y[l] = 0; end
    end else begin
      cur = '0;
      cur.ph = ph; cur.hc = vin.hcount; cur.vc = vin.vcount;
      cur.hs = vin.hsync; cur.vs = vin.vsync;
      cur.hb = vin.hblnk; cur.vb = vin.vblnk; cur.rgb = vin.rgb;
      mh = int'(vin.hcount); mv = int'(vin.vcount);
      for (int l = 0; l < N; l++) begin
        if (s_en[l] && !vin.hblnk && !vin.vblnk &&
            mh >= s_x[l] && mh < s_x[l] + SW &&
            mv >= s_y[l] && mv < s_y[l] + SH) begin
          ma = (mv - s_y[l]) * SW + (mh - s_x[l]);
          cur.addr[l*AW +: AW] = AW'(ma);
          mp = rom_fn(l, ma);
          if (mp != KEY) begin
            if (cur.nopq == 0) cur.rgb = mp;
            cur.nopq = cur.nopq + 4'd1;
          end
        end
      end
`ifdef SPRITE_COLLISION_EN
      if (vin.vblnk && !pvb) begin
        mcol = mflag;
        mflag = (e2.nopq >= 2);
      end else if (e2.nopq >= 2) begin
        mflag = 1'b1;
      end
`endif
      if (vin.vblnk && !pvb) begin
        s_en = layer_en;
        for (int l = 0; l < N; l++) begin
          s_x[l] = int'(xpos[l]);
          s_y[l] = int'(ypos[l]);
        end
      end
      pvb = vin.vblnk;
      e2 = e1;
      e1 = cur;
    end
  end

  // Per-cycle comparison plus literal spot values at chosen pixels.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("timing",
          {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
           vout.hblnk, vout.vblnk},
          {e2.hc, e2.vc, e2.hs, e2.vs, e2.hb, e2.vb});
      chk("rgb", vout.rgb, e2.rgb);
      chk("rom_addr", rom_addr, e1.addr);
      chk("collision", collision, mcol);
      if (e2.ph == 1 && e2.vc == 80 && e2.hc == 130)
        chk("p1_in", vout.rgb, 12'hF00);
      if (e2.ph == 1 && e2.vc == 50 && e2.hc == 100)
        chk("p1_tl", vout.rgb, 12'hF00);
      if (e2.ph == 1 && e2.vc == 113 && e2.hc == 163)
        chk("p1_br", vout.rgb, 12'hF00);
      if (e2.ph == 1 && e2.vc == 80 && e2.hc == 164)
        chk("p1_right", vout.rgb, 12'h910);
      if (e2.ph == 1 && e2.vc == 80 && e2.hc == 99)
        chk("p1_left", vout.rgb, 12'h8D0);
      if (e2.ph == 1 && e2.vc == 114 && e2.hc == 130)
        chk("p1_below", vout.rgb, 12'h0B2);
      if (e2.ph == 2 && e2.vc == 201 && e2.hc == 210)
        chk("p2_l0win", vout.rgb, 12'hF00);
      if (e2.ph == 2 && e2.vc == 201 && e2.hc == 199)
        chk("p2_bg", vout.rgb, 12'h1C9);
      if (e2.ph == 3 && e2.vc == 201 && e2.hc == 210) begin
        chk("p3_l1show", vout.rgb, 12'hA4A);
        chk("p3_col", collision, COLX);
      end
      if (e2.ph == 4 && e2.vc == 300 && e2.hc == 310) begin
        chk("p4_oldx", vout.rgb, 12'hF00);
        chk("p4_col", collision, 1'b0);
      end
      if (e2.ph == 5 && e2.vc == 300 && e2.hc == 310)
        chk("p5_oldgone", vout.rgb, 12'hDAC);
      if (e2.ph == 5 && e2.vc == 300 && e2.hc == 410)
        chk("p5_newx", vout.rgb, 12'hF00);
      if (e1.ph == 6 && e1.vc == 590 && e1.hc == 790)
        chk("p6_addr650", rom_addr[0], 12'd650);
      if (e2.ph == 6 && e2.vc == 599 && e2.hc == 799)
        chk("p6_corner", vout.rgb, 12'hCD3);
      if (e2.ph == 6 && e2.vc == 590 && e2.hc == 800)
        chk("p6_clip", vout.rgb, 12'h80E);
      if (e2.ph == 7 && e2.vc == 1 && e2.hc == 5)
        chk("p7_nowrapx", vout.rgb, 12'h141);
      if (e2.ph == 7 && e2.vc == 1 && e2.hc == 20)
        chk("p7_nowrapy", vout.rgb, 12'h501);
      if (e2.ph == 8 && e2.vc == 51 && e2.hc == 130)
        chk("p8_before", vout.rgb, 12'hF00);
      if (e2.ph == 8 && e2.vc == 54 && e2.hc == 130)
        chk("p8_passthru", vout.rgb, 12'h0B6);
      if (e2.ph == 9 && e2.vc == 54 && e2.hc == 130)
        chk("p9_back", vout.rgb, 12'hF00);
    end
  end

  task automatic step(input int h, input int v, input bit hb, input bit vb);
    logic [10:0] hh;
    logic [10:0] vv;
    @(negedge clk);
    hh = 11'(h);
    vv = 11'(v);
    vin.hcount = hh;
    vin.vcount = vv;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.hsync  = hh[4];
    vin.vsync  = vv[1];
    vin.rgb    = {hh[5:0], vv[5:0]};
  endtask

  task automatic scan(input int h0, input int h1, input int v0, input int v1);
    for (int v = v0; v <= v1; v++)
      for (int h = h0; h <= h1; h++)
        step(h, v, h > 799, v > 599);
  endtask

  task automatic vblank(input int n);
    step(0, 600, 1'b1, 1'b0);
    repeat (n) step(0, 600, 1'b1, 1'b1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_vga"},
        {vout.hcount, vout.vcount, vout.hsync, vout.vsync,
         vout.hblnk, vout.vblnk, vout.rgb}, 64'd0);
    chk({nm, "_addr"}, rom_addr, 64'd0);
    chk({nm, "_col"}, collision, 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ph = 4'd0;
    layer_en = '0; xpos = '0; ypos = '0;
    rom_pat = '0; rom_col = '0;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0;
    vin.vsync = 1'b0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
    vin.rgb = '0;
    #3;
    chk_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    ph = 4'd1;
    layer_en = 4'b0001; xpos[0] = 12'd100; ypos[0] = 12'd50;
    rom_col[0] = 12'hF00;
    vblank(3);
    scan(96, 168, 46, 118);

    ph = 4'd2;
    layer_en = 4'b0011;
    xpos[1] = 12'd200; ypos[1] = 12'd200;
    xpos[0] = 12'd200; ypos[0] = 12'd200;
    rom_pat[1] = 1'b1;
    vblank(3);
    scan(195, 265, 198, 203);

    ph = 4'd3;
    rom_col[0] = KEY;
    vblank(3);
    scan(195, 265, 198, 203);

    ph = 4'd4;
    layer_en = 4'b0001; xpos[0] = 12'd300; ypos[0] = 12'd290;
    rom_col[0] = 12'hF00;
    vblank(3);
    scan(295, 470, 298, 299);
    xpos[0] = 12'd400;
    scan(295, 470, 300, 301);

    ph = 4'd5;
    vblank(3);
    scan(295, 470, 300, 300);

    ph = 4'd6;
    xpos[0] = 12'd780; ypos[0] = 12'd580; rom_pat[0] = 1'b1;
    vblank(3);
    scan(776, 803, 576, 603);

    ph = 4'd7;
    layer_en = 4'b0101;
    xpos[0] = 12'd4060; ypos[0] = 12'd0; rom_pat[0] = 1'b0;
    xpos[2] = 12'd10; ypos[2] = 12'd4090; rom_col[2] = 12'h00F;
    vblank(3);
    scan(0, 40, 0, 2);

    ph = 4'd8;
    layer_en = 4'b0001; xpos[0] = 12'd100; ypos[0] = 12'd50;
    vblank(3);
    scan(96, 170, 50, 52);
    for (int h = 96; h <= 120; h++) step(h, 53, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int h = 121; h <= 170; h++) step(h, 53, 1'b0, 1'b0);
    scan(96, 170, 54, 55);

    ph = 4'd9;
    vblank(3);
    scan(96, 170, 54, 54);
    vblank(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
